// File: rtl/dsp_fetch_pkg.sv
// Shared types and defaults for the DSP instruction fetch unit.
// Holds the fetch FSM encoding and the default bus widths and reset vector.
package dsp_fetch_pkg;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HOLD = 1'b1
  } fetch_state_t;

  localparam int          DSP_ADDR_W     = 16;
  localparam int          DSP_INSTR_W    = 16;
  localparam logic [15:0] DSP_RESET_ADDR = 16'h0000;

endpackage

// File: rtl/dsp_fetch_skid.sv
// Skid register for the fetch unit.
// It catches the ROM word that returns while decode is stalled; clear has priority over load.
module dsp_fetch_skid
  import dsp_fetch_pkg::*;
#(
  parameter int ADDR_W  = DSP_ADDR_W,
  parameter int INSTR_W = DSP_INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc,
  output logic               skid_valid,
  output logic [INSTR_W-1:0] skid_instr,
  output logic [ADDR_W-1:0]  skid_pc
);

  logic               valid_reg;
  logic [INSTR_W-1:0] instr_reg;
  logic [ADDR_W-1:0]  pc_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_reg <= 1'b0;
      instr_reg <= '0;
      pc_reg    <= '0;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      instr_reg <= load_instr;
      pc_reg    <= load_pc;
    end
  end

  assign skid_valid = valid_reg;
  assign skid_instr = instr_reg;
  assign skid_pc    = pc_reg;

endmodule

// File: rtl/dsp_fetch.sv
// DSP instruction fetch: program counter, one ROM read per cycle, registered output
// to decode, branch redirect with wrong-path flush, and a skid slot for decode stalls.
module dsp_fetch
  import dsp_fetch_pkg::*;
#(
  parameter int                ADDR_W     = DSP_ADDR_W,
  parameter int                INSTR_W    = DSP_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(DSP_RESET_ADDR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               jump_flag,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               stall,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  fetch_state_t       state_reg, state_next;
  logic [ADDR_W-1:0]  fetch_pc_reg, fetch_pc_next;
  logic               inflight_valid_reg, inflight_valid_next;
  logic [ADDR_W-1:0]  inflight_pc_reg, inflight_pc_next;
  logic [INSTR_W-1:0] instr_reg, instr_next;
  logic [ADDR_W-1:0]  instr_pc_reg, instr_pc_next;
  logic               instr_valid_reg, instr_valid_next;

  logic               skid_load, skid_clear;
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc;

  dsp_fetch_skid #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .clear      (skid_clear),
    .load_instr (imem_rdata),
    .load_pc    (inflight_pc_reg),
    .skid_valid (skid_valid),
    .skid_instr (skid_instr),
    .skid_pc    (skid_pc)
  );

  // The redirect target goes straight to the ROM so the jump costs only one bubble.
  assign imem_en   = rst & (jump_flag | ~stall);
  assign imem_addr = jump_flag ? jump_addr : fetch_pc_reg;

  always_comb begin
    state_next          = state_reg;
    fetch_pc_next       = fetch_pc_reg;
    inflight_valid_next = inflight_valid_reg;
    inflight_pc_next    = inflight_pc_reg;
    instr_next          = instr_reg;
    instr_pc_next       = instr_pc_reg;
    instr_valid_next    = instr_valid_reg;
    skid_load           = 1'b0;
    skid_clear          = 1'b0;

    if (jump_flag) begin
      fetch_pc_next       = jump_addr + PC_ONE;
      inflight_pc_next    = jump_addr;
      inflight_valid_next = 1'b1;
      skid_clear          = 1'b1;
      instr_valid_next    = 1'b0;
      state_next          = FETCH_RUN;
    end else begin
      unique case (state_reg)
        FETCH_RUN: begin
          if (!stall) begin
            fetch_pc_next       = fetch_pc_reg + PC_ONE;
            inflight_valid_next = 1'b1;
            inflight_pc_next    = fetch_pc_reg;
            instr_next          = imem_rdata;
            instr_pc_next       = inflight_pc_reg;
            instr_valid_next    = inflight_valid_reg;
          end else begin
            // The word already on its way back is parked; no new read is issued.
            skid_load           = inflight_valid_reg;
            inflight_valid_next = 1'b0;
            state_next          = FETCH_HOLD;
          end
        end
        FETCH_HOLD: begin
          if (!stall) begin
            instr_next          = skid_instr;
            instr_pc_next       = skid_pc;
            instr_valid_next    = skid_valid;
            skid_clear          = 1'b1;
            fetch_pc_next       = fetch_pc_reg + PC_ONE;
            inflight_valid_next = 1'b1;
            inflight_pc_next    = fetch_pc_reg;
            state_next          = FETCH_RUN;
          end
        end
        default: state_next = FETCH_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg          <= FETCH_RUN;
      fetch_pc_reg       <= RESET_ADDR;
      inflight_valid_reg <= 1'b0;
      inflight_pc_reg    <= '0;
      instr_reg          <= '0;
      instr_pc_reg       <= '0;
      instr_valid_reg    <= 1'b0;
    end else begin
      state_reg          <= state_next;
      fetch_pc_reg       <= fetch_pc_next;
      inflight_valid_reg <= inflight_valid_next;
      inflight_pc_reg    <= inflight_pc_next;
      instr_reg          <= instr_next;
      instr_pc_reg       <= instr_pc_next;
      instr_valid_reg    <= instr_valid_next;
    end
  end

  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_valid = instr_valid_reg;

endmodule

// File: tb/tb_dsp_fetch.sv
// Directed bench for dsp_fetch: a behavioural ROM returns 16'hA000+addr one cycle after each read.
// Inputs change and outputs are sampled on the falling edge.
module tb_dsp_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag;
  logic [15:0] jump_addr;
  logic        stall;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dsp_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .jump_flag   (jump_flag),
    .jump_addr   (jump_addr),
    .stall       (stall),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid)
  );

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 16'hA000 + imem_addr;
  end

  function automatic logic [15:0] rom_val(input logic [15:0] a);
    return 16'hA000 + a;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic expect_instr(input string tag, input logic [15:0] pc);
    check({tag, " valid"}, 32'(instr_valid), 32'd1);
    check({tag, " pc"}, 32'(instr_pc), 32'(pc));
    check({tag, " instr"}, 32'(instr), 32'(rom_val(pc)));
    $display("[%0t] %s: instr_pc=%h instr=%h valid=%0d", $time, tag, instr_pc, instr, instr_valid);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b0;
    jump_flag = 1'b0;
    jump_addr = 16'h0000;
    stall     = 1'b0;
    repeat (3) tick();
    check("reset valid", 32'(instr_valid), 32'd0);
    check("reset instr", 32'(instr), 32'd0);
    check("reset pc", 32'(instr_pc), 32'd0);
    check("reset imem_en", 32'(imem_en), 32'd0);

    // Release reset and stream from RESET_ADDR.
    rst = 1'b1;
    #1;
    check("start imem_en", 32'(imem_en), 32'd1);
    check("start imem_addr", 32'(imem_addr), 32'h0000);
    tick();
    check("edge1 valid", 32'(instr_valid), 32'd0);
    tick();
    expect_instr("stream0", 16'h0000);
    for (int k = 1; k <= 5; k++) begin
      tick();
      expect_instr("stream", 16'(k));
    end

    // Redirect while PC 5 is on the output; 6 and 7 must be dropped.
    jump_flag = 1'b1;
    jump_addr = 16'h0040;
    #1;
    check("jump imem_en", 32'(imem_en), 32'd1);
    check("jump imem_addr", 32'(imem_addr), 32'h0040);
    tick();
    jump_flag = 1'b0;
    check("jump bubble", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_instr("after jump", 16'(16'h0040 + k));
    end

    // Three-cycle stall with 0x42 on the output.
    stall = 1'b1;
    #1;
    check("stall imem_en", 32'(imem_en), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_instr("stalled", 16'h0042);
    end
    stall = 1'b0;
    #1;
    check("unstall imem_en", 32'(imem_en), 32'd1);
    check("unstall imem_addr", 32'(imem_addr), 32'h0044);
    for (int k = 1; k <= 3; k++) begin
      tick();
      expect_instr("after stall", 16'(16'h0042 + k));
    end

    // Jump and stall together: target waits in the skid until stall drops.
    stall     = 1'b1;
    jump_flag = 1'b1;
    jump_addr = 16'h0080;
    #1;
    check("jstall imem_en", 32'(imem_en), 32'd1);
    check("jstall imem_addr", 32'(imem_addr), 32'h0080);
    tick();
    jump_flag = 1'b0;
    check("jstall bubble", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("jstall held", 32'(instr_valid), 32'd0);
    end
    stall = 1'b0;
    tick();
    expect_instr("jstall target", 16'h0080);
    tick();
    expect_instr("jstall next", 16'h0081);

    // Address wrap-around.
    jump_flag = 1'b1;
    jump_addr = 16'hFFFE;
    tick();
    jump_flag = 1'b0;
    check("wrap bubble", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_instr("wrap", 16'(16'hFFFE + k));
    end

    // Reset while holding with a full skid.
    stall = 1'b1;
    tick();
    check("hold skid full", 32'(dut.skid_valid), 32'd1);
    rst = 1'b0;
    tick();
    check("rst hold valid", 32'(instr_valid), 32'd0);
    check("rst hold instr", 32'(instr), 32'd0);
    check("rst hold pc", 32'(instr_pc), 32'd0);
    check("rst hold skid", 32'(dut.skid_valid), 32'd0);
    check("rst hold imem_en", 32'(imem_en), 32'd0);
    rst   = 1'b1;
    stall = 1'b0;
    #1;
    check("restart imem_addr", 32'(imem_addr), 32'h0000);
    tick();
    check("restart edge1 valid", 32'(instr_valid), 32'd0);
    tick();
    expect_instr("restart0", 16'h0000);
    tick();
    expect_instr("restart1", 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
